// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared state encoding and grant codes for the memory port arbiter
package mem_arb_pkg;
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  localparam logic GRANT_IF = 1'b0;
  localparam logic GRANT_DM = 1'b1;
endpackage

// File: rtl/mux_2x1.sv
// mux_2x1: parameterised two-input multiplexer
module mux_2x1 #(
  parameter int BIT_SIZE = 32
) (
  input  logic [BIT_SIZE-1:0] in0_i,
  input  logic [BIT_SIZE-1:0] in1_i,
  input  logic                sel_i,
  output logic [BIT_SIZE-1:0] out_o
);
  assign out_o = sel_i ? in1_i : in0_i;
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin sharing of one memory port between fetch and load/store
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_SIZE      = 32,
  parameter int DATA_SIZE      = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 ifReq,
  input  logic [ADDR_SIZE-1:0] ifAddr,
  output logic [DATA_SIZE-1:0] ifRdata,
  output logic                 ifDone,
  input  logic                 dmReq,
  input  logic                 dmWe,
  input  logic [ADDR_SIZE-1:0] dmAddr,
  input  logic [DATA_SIZE-1:0] dmWdata,
  output logic [DATA_SIZE-1:0] dmRdata,
  output logic                 dmDone,
  output logic                 memReq,
  output logic                 memWe,
  output logic [ADDR_SIZE-1:0] memAddr,
  output logic [DATA_SIZE-1:0] memWdata,
  input  logic [DATA_SIZE-1:0] memRdata,
  input  logic                 memAck,
  output logic                 grantSel,
  output logic                 errFlag
);
  localparam int CW = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CYCLES > 0 ? TIMEOUT_CYCLES - 1 : 0);
  state_t               state_q;
  logic                 last_q;
  logic [CW-1:0]        cnt_q;
  logic                 win_dm;
  logic                 timed_out;
  logic [ADDR_SIZE-1:0] sel_addr;
  logic [DATA_SIZE-1:0] sel_wdata;
  logic                 sel_we;
  // on contention the requester that did not win last time goes first
  assign win_dm    = dmReq & (~ifReq | (last_q == GRANT_IF));
  assign timed_out = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_MAX);
  mux_2x1 #(.BIT_SIZE(ADDR_SIZE)) u_addr_mux (
    .in0_i(ifAddr), .in1_i(dmAddr), .sel_i(win_dm), .out_o(sel_addr)
  );
  mux_2x1 #(.BIT_SIZE(DATA_SIZE)) u_wdata_mux (
    .in0_i('0), .in1_i(dmWdata), .sel_i(win_dm), .out_o(sel_wdata)
  );
  mux_2x1 #(.BIT_SIZE(1)) u_we_mux (
    .in0_i(1'b0), .in1_i(dmWe), .sel_i(win_dm), .out_o(sel_we)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      memReq   <= 1'b0;
      memWe    <= 1'b0;
      memAddr  <= '0;
      memWdata <= '0;
      ifRdata  <= '0;
      dmRdata  <= '0;
      ifDone   <= 1'b0;
      dmDone   <= 1'b0;
      grantSel <= GRANT_IF;
      errFlag  <= 1'b0;
      last_q   <= GRANT_DM;
      cnt_q    <= '0;
    end else begin
      case (state_q)
        IDLE: if (ifReq | dmReq) begin
          state_q  <= ACCESS;
          memReq   <= 1'b1;
          grantSel <= win_dm;
          last_q   <= win_dm;
          memAddr  <= sel_addr;
          memWe    <= sel_we;
          memWdata <= sel_wdata;
        end
        ACCESS: if (memAck || timed_out) begin
          state_q <= DONE;
          memReq  <= 1'b0;
          ifDone  <= grantSel == GRANT_IF;
          dmDone  <= grantSel == GRANT_DM;
          errFlag <= errFlag | ~memAck;
          if (memAck && !memWe && grantSel == GRANT_DM) dmRdata <= memRdata;
          if (memAck && !memWe && grantSel == GRANT_IF) ifRdata <= memRdata;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
        DONE: begin
          state_q <= IDLE;
          ifDone  <= 1'b0;
          dmDone  <= 1'b0;
          cnt_q   <= '0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule
